cla_adder_pipe: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor; next generation of the fixed 5-bit registered CLA.
- Splits a WIDTH-bit operation into GROUP-bit lookahead slices, one slice per pipeline stage, with carry registered between stages.
- Adds carry-in, subtract mode, signed-overflow flag and valid/ready flow control.
- Used in datapaths needing wide adds at high clock rate.

---
 rtl/cla_adder_pipe.sv | 131 +++++++++++++
 tb/tb_cla_adder_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_adder_pipe.sv
`timescale 1ns / 1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | cla_adder_pipe : pipelined carry-lookahead adder/subtractor, one       |
// |                  GROUP-bit lookahead slice per stage, valid/ready.     |
// | Revision       : 1.0                                                   |
// +------------------------------------------------------------------------+
module cla_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int NG = WIDTH / GROUP;

  generate
    if ((WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_bad_params
      $error("cla_adder_pipe: WIDTH must be a non-zero multiple of GROUP");
    end
  endgenerate

  // Returns {carry out, carry into slice MSB, sum bits}; every carry is a
  // flat sum-of-products of g/p terms so nothing ripples inside the slice.
  function automatic logic [GROUP+1:0] cla_slice(
    input logic [GROUP-1:0] a,
    input logic [GROUP-1:0] b,
    input logic             ci
  );
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             t;
    g = a & b;
    p = a ^ b;
    for (int i = 0; i <= GROUP; i++) begin
      t = ci;
      for (int m = 0; m < i; m++) t = t & p[m];
      c[i] = t;
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int m = j + 1; m < i; m++) t = t & p[m];
        c[i] = c[i] | t;
      end
    end
    return {c[GROUP], c[GROUP-1], p ^ c[GROUP-1:0]};
  endfunction

  // x_q holds finished sum slices in its top bits and the still-unconsumed
  // operand-A bits in its low bits; bsk_q is the matching skewed operand B.
  logic             valid_q [NG];
  logic [WIDTH-1:0] x_q     [NG];
  logic [WIDTH-1:0] bsk_q   [NG];
  logic             carry_q [NG];
  logic             ovf_q;

  logic             stage_v [NG];
  logic [WIDTH-1:0] stage_x [NG];
  logic [WIDTH-1:0] stage_b [NG];
  logic             stage_c [NG];
  logic [GROUP+1:0] slice_r [NG];
  logic [WIDTH-1:0] x_d     [NG];
  logic [WIDTH-1:0] bsk_d   [NG];
  logic             stall;

  assign stall      = valid_q[NG-1] & ~out_ready_i;
  assign in_ready_o = ~stall;

  always_comb begin
    stage_v[0] = in_valid_i;
    stage_x[0] = a_i;
    stage_b[0] = b_i ^ {WIDTH{sub_i}};
    stage_c[0] = sub_i | cin_i;
    for (int k = 1; k < NG; k++) begin
      stage_v[k] = valid_q[k-1];
      stage_x[k] = x_q[k-1];
      stage_b[k] = bsk_q[k-1];
      stage_c[k] = carry_q[k-1];
    end
    for (int k = 0; k < NG; k++) begin
      slice_r[k] = cla_slice(stage_x[k][GROUP-1:0], stage_b[k][GROUP-1:0], stage_c[k]);
      x_d[k]     = (stage_x[k] >> GROUP) | (WIDTH'(slice_r[k][GROUP-1:0]) << (WIDTH - GROUP));
      bsk_d[k]   = (stage_b[k] >> GROUP) | (stage_b[k] << (WIDTH - GROUP));
    end
  end

  // Bubbles advance the valid chain but leave data registers untouched,
  // so the outputs keep their last value while out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NG; k++) begin
        valid_q[k] <= 1'b0;
        x_q[k]     <= '0;
        bsk_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < NG; k++) begin
        valid_q[k] <= stage_v[k];
        if (stage_v[k]) begin
          x_q[k]     <= x_d[k];
          bsk_q[k]   <= bsk_d[k];
          carry_q[k] <= slice_r[k][GROUP+1];
        end
      end
      if (stage_v[NG-1]) begin
        ovf_q <= slice_r[NG-1][GROUP+1] ^ slice_r[NG-1][GROUP];
      end
    end
  end

  assign out_valid_o = valid_q[NG-1];
  assign sum_o       = x_q[NG-1];
  assign cout_o      = carry_q[NG-1];
  assign ovf_o       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_adder_pipe.sv
`timescale 1ns / 1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_cla_adder_pipe : bench for cla_adder_pipe at 16/4 and 5/5.          |
// | Revision          : 1.0                                                |
// +------------------------------------------------------------------------+
module tb_cla_adder_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0, out_ready16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0;
  logic        in_ready16, out_valid16, cout16, ovf16;
  logic [15:0] sum16;

  logic        in_valid5 = 1'b0, cin5 = 1'b0, sub5 = 1'b0, out_ready5 = 1'b1;
  logic [4:0]  a5 = '0, b5 = '0;
  logic        in_ready5, out_valid5, cout5, ovf5;
  logic [4:0]  sum5;

  cla_adder_pipe #(.WIDTH(16), .GROUP(4)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid16), .in_ready_o(in_ready16),
    .a_i(a16), .b_i(b16), .cin_i(cin16), .sub_i(sub16),
    .out_valid_o(out_valid16), .out_ready_i(out_ready16),
    .sum_o(sum16), .cout_o(cout16), .ovf_o(ovf16)
  );

  cla_adder_pipe #(.WIDTH(5), .GROUP(5)) u_dut5 (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid5), .in_ready_o(in_ready5),
    .a_i(a5), .b_i(b5), .cin_i(cin5), .sub_i(sub5),
    .out_valid_o(out_valid5), .out_ready_i(out_ready5),
    .sum_o(sum5), .cout_o(cout5), .ovf_o(ovf5)
  );

  int applied = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input logic [31:0] act);
    applied++;
    miscompares++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  // Reference: plain integer arithmetic; returns {ovf, cout, sum(16b)}.
  function automatic logic [17:0] model(input int w, input longint a, input longint b,
                                        input bit cin, input bit sub);
    longint m, h, u, sa, sb, s;
    logic [15:0] sm;
    bit co, ov;
    m  = longint'(1) << w;
    h  = m / 2;
    u  = sub ? (a - b) : (a + b + longint'(cin));
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    s  = sub ? (sa - sb) : (sa + sb + longint'(cin));
    sm = 16'((u + m) % m);
    co = sub ? (a >= b) : (u >= m);
    ov = (s >= h) || (s < -h);
    return {ov, co, sm};
  endfunction

  task automatic single16(input vec_t v, input string name);
    int cnt;
    @(negedge clk);
    a16 = v.a; b16 = v.b; cin16 = v.cin; sub16 = v.sub;
    in_valid16 = 1'b1; out_ready16 = 1'b1;
    @(negedge clk);
    in_valid16 = 1'b0;
    cnt = 0;
    while (!out_valid16 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({name, "_valid"}, 32'(out_valid16), 32'd1);
    check(name, {ovf16, cout16, sum16}, {v.ovf, v.cout, v.sum});
  endtask

  task automatic run_stream(input bit w5, input int nbeats, input string tag);
    logic [17:0] exp_q[$];
    logic [17:0] act;
    logic [11:0] idx;
    longint av, bv;
    bit ci, sb, ordy, ov, ir;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < nbeats && cyc < nbeats * 8 + 200) begin
      @(negedge clk);
      cyc++;
      ordy = ($urandom_range(0, 3) != 0);
      if (w5) out_ready5 = ordy; else out_ready16 = ordy;
      #1;
      ov  = w5 ? out_valid5 : out_valid16;
      ir  = w5 ? in_ready5 : in_ready16;
      act = w5 ? {ovf5, cout5, 11'd0, sum5} : {ovf16, cout16, sum16};
      if (ov && ordy) begin
        if (exp_q.size() == 0) note_fail({tag, "_spurious"}, 32'(act));
        else check(tag, 32'(act), 32'(exp_q.pop_front()));
        got++;
      end
      if (sent < nbeats && ir && $urandom_range(0, 4) != 0) begin
        if (w5) begin
          idx = 12'(sent);
          av = longint'(idx[4:0]); bv = longint'(idx[9:5]); ci = idx[10]; sb = idx[11];
          a5 = idx[4:0]; b5 = idx[9:5]; cin5 = ci; sub5 = sb; in_valid5 = 1'b1;
        end else begin
          av = longint'($urandom_range(0, 65535)); bv = longint'($urandom_range(0, 65535));
          ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
          a16 = 16'(av); b16 = 16'(bv); cin16 = ci; sub16 = sb; in_valid16 = 1'b1;
        end
        exp_q.push_back(model(w5 ? 5 : 16, av, bv, ci, sb));
        sent++;
      end else begin
        if (w5) in_valid5 = 1'b0; else in_valid16 = 1'b0;
      end
    end
    in_valid5 = 1'b0; in_valid16 = 1'b0; out_ready5 = 1'b1; out_ready16 = 1'b1;
    if (got < nbeats) note_fail({tag, "_timeout"}, 32'(got));
  endtask

  task automatic backpressure();
    logic [15:0] q[$];
    int next_i, got, stall_left, cyc;
    bit stalled_once;
    next_i = 1; got = 0; stall_left = 0; cyc = 0; stalled_once = 1'b0;
    while (got < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (!stalled_once && got == 1 && out_valid16) begin
        stalled_once = 1'b1;
        stall_left = 3;
      end
      out_ready16 = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        check("bp_stall_in_ready", 32'(in_ready16), 32'd0);
        check("bp_stall_hold", {out_valid16, sum16}, {1'b1, 16'd4});
        stall_left--;
      end else if (out_valid16) begin
        if (q.size() == 0) note_fail("bp_extra", 32'(sum16));
        else check("bp_order", 32'(sum16), 32'(q.pop_front()));
        got++;
      end
      if (next_i <= 6 && in_ready16) begin
        a16 = 16'(next_i); b16 = 16'(next_i); cin16 = 1'b0; sub16 = 1'b0;
        in_valid16 = 1'b1;
        q.push_back(16'(2 * next_i));
        next_i++;
      end else begin
        in_valid16 = 1'b0;
      end
    end
    in_valid16 = 1'b0; out_ready16 = 1'b1;
    if (got < 6) note_fail("bp_timeout", 32'(got));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_no_dup", 32'(out_valid16), 32'd0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached with %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[4]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[5]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[6]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[9]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    tbl[10] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};

    // Reset held with a beat offered: nothing may be accepted.
    in_valid16 = 1'b1; a16 = 16'd3; b16 = 16'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid16), 32'd0);
      check("rst_sum", 32'(sum16), 32'd0);
    end
    check("rst_in_ready", 32'(in_ready16), 32'd1);
    check("rst_out5", {out_valid5, cout5, ovf5, sum5}, 32'd0);

    // Release; the pending beat is accepted on the next edge.
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (n == 0) in_valid16 = 1'b0;
      check("latency_valid", 32'(out_valid16), (n == 3) ? 32'd1 : 32'd0);
    end
    check("latency_result", {ovf16, cout16, sum16}, {1'b0, 1'b0, 16'h0007});

    for (int i = 0; i < 11; i++) single16(tbl[i], $sformatf("table%0d", i));

    backpressure();

    // Asynchronous reset in the middle of a stream.
    out_ready16 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a16 = 16'(i + 10); b16 = 16'd1; cin16 = 1'b0; sub16 = 1'b0; in_valid16 = 1'b1;
    end
    @(negedge clk);
    #1;
    check("mid_pre_valid", 32'(out_valid16), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid16), 32'd0);
    check("async_rst_sum", 32'(sum16), 32'd0);
    @(negedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'(out_valid16), 32'd0);
    end

    run_stream(1'b0, 300, "rand16");
    run_stream(1'b1, 4096, "exh5");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
